framebuffer_ctrl: RTL and testbench
===================================

# framebuffer_ctrl

- Double-buffered 4-bit palette-index framebuffer sitting directly upstream of the screen driver.
- Accepts a linear pixel stream from the renderer over a valid/ready handshake and writes it into the back bank.
- Serves the VGA and LCD read ports from the front bank, with 1-cycle read latency.
- Swaps banks at the first frame-sync edge after a complete frame has been written, so scan-out never tears.

## Interface
Parameters:
- H_RES, 640, active pixels per line
- V_RES, 480, active lines per frame
- COLOR_W, 4, palette index width

Ports (all in the pixel_clock domain):
- pixel_clock  in  1  pixel clock
- pixel_reset  in  1  reset, asynchronous, active-high
- pix_valid  in  1  renderer pixel valid
- pix_ready  out  1  block accepts pixel this cycle
- pix_data  in  COLOR_W  palette index
- pix_last  in  1  marks last pixel of frame
- frame_sync  in  1  level, high during vertical blank; rising edge is the swap point
- addr_vga  in  19  VGA read address
- data_vga  out  COLOR_W  VGA read data
- addr_lcd  in  19  LCD read address
- data_lcd  out  COLOR_W  LCD read data
- front_bank  out  1  bank currently scanned out
- frame_err  out  1  sticky: pix_last misaligned with pixel count

## Operation
- PIXELS = H_RES*V_RES = 307200; write address wr_addr counts 0..PIXELS-1.
- A beat is accepted when pix_valid && pix_ready. It writes pix_data to back bank at wr_addr, then wr_addr increments.
- State FILL:
  - pix_ready = 1.
  - Frame ends on the accepted beat with wr_addr == PIXELS-1 or with pix_last == 1, whichever comes first.
  - At frame end: wr_addr <= 0, go to WAIT_SWAP.
- frame_err:
  - Set if the end beat has pix_last != (wr_addr == PIXELS-1).
  - Cleared only by reset.
- State WAIT_SWAP:
  - pix_ready = 0.
  - On a frame_sync rising edge (frame_sync high, registered previous value low): toggle front_bank, go to FILL.
- Simultaneous events: a frame-end beat coinciding with a frame_sync rising edge does not swap on that edge. The swap waits for the next rising edge.
- Reads:
  - data_x <= (addr_x < PIXELS) ? front[addr_x] : 0, registered.
  - Both ports are independent and may use any address each cycle.
- Reset mid-frame: state FILL, wr_addr 0, partially written back bank is abandoned. Memory contents are not cleared.

## Timing
- Reset values:
  - pix_ready 0 while pixel_reset is high; 1 from the first clock edge after deassertion.
  - data_vga/data_lcd 0, front_bank 0, frame_err 0, state FILL, wr_addr 0.
  - Registered frame_sync history resets to 1, so a level high at reset release is not an edge.
- Read latency: address at edge N -> data valid after edge N+1.
- Write latency: a beat accepted at edge N is readable from that bank from edge N+1.
- Swap: edge-detect adds 1 cycle. front_bank toggles at edge E+1, where E is the first edge sampling frame_sync high.
  - Reads issued at or after edge E+1 return the new bank.
- pix_ready is combinational from state only, never from pix_valid.

## Configuration
- FB_DOUBLE_BUFFER_EN defined:
  - Behaviour as above, two banks.
- FB_DOUBLE_BUFFER_EN undefined:
  - Single bank; writes go to the scanned bank.
  - No WAIT_SWAP state: frame end returns directly to FILL with wr_addr 0.
  - front_bank tied 0; frame_sync is ignored.
  - frame_err is still tracked.

## Structure
- Package fb_pkg holds:
  - H_RES, V_RES, PIXELS, FB_ADDR_W = 19, COLOR_W
  - typedef color_t, typedef fb_addr_t
  - enum fb_state_t {FILL, WAIT_SWAP}
- Sub-module fb_bank:
  - One synchronous write port and two synchronous read ports, PIXELS x COLOR_W, inferred BRAM.
  - Instantiated twice, or once without FB_DOUBLE_BUFFER_EN.
- Read mux selects the bank by registered front_bank, aligned with the 1-cycle read latency.

## Test plan
- Reset release with frame_sync high -> pix_ready 1 next cycle; front_bank stays 0; no swap until frame_sync goes low then high.
- Stream 307200 beats (value = index mod 16), pix_last on last, pulse frame_sync -> front_bank = 1. Read addr 1000 -> data 8 one cycle later; frame_err 0.
- pix_last asserted on beat 99 -> frame ends, frame_err = 1, pix_ready 0 until next frame_sync edge; wr_addr restarts at 0.
- Frame-end beat in same cycle as frame_sync rising edge -> no swap; swap on following edge only.
- Read addr 307200 and 0x7FFFF on both ports -> data 0.
- pixel_reset pulsed mid-frame at beat 5000 -> all outputs at reset values; next stream starts writing address 0.

Source files
------------

// File: rtl/fb_pkg.sv
// ============================================================================
// Module  : fb_pkg
// Brief   : Shared sizes, types and FSM states for the framebuffer controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fb_pkg;

    localparam int H_RES     = 640;
    localparam int V_RES     = 480;
    localparam int PIXELS    = H_RES * V_RES;
    localparam int FB_ADDR_W = 19;
    localparam int COLOR_W   = 4;

    typedef logic [COLOR_W-1:0]   color_t;
    typedef logic [FB_ADDR_W-1:0] fb_addr_t;

    typedef enum logic [0:0] {
        FILL      = 1'b0,
        WAIT_SWAP = 1'b1
    } fb_state_t;

endpackage

`default_nettype wire

// File: rtl/fb_bank.sv
// ============================================================================
// Module  : fb_bank
// Brief   : One framebuffer bank: a synchronous write port and two
//           synchronous read ports (read-before-write), block-RAM style.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_bank
    import fb_pkg::*;
#(
    parameter int DEPTH = PIXELS,
    parameter int WIDTH = COLOR_W,
    parameter int IDX_W = FB_ADDR_W
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx_a,
    input  logic [IDX_W-1:0] rd_idx_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wr_idx] <= wr_data;
        end
        rd_data_a <= r_mem[rd_idx_a];
        rd_data_b <= r_mem[rd_idx_b];
    end

endmodule

`default_nettype wire

// File: rtl/framebuffer_ctrl.sv
// ============================================================================
// Module  : framebuffer_ctrl
// Brief   : Palette-index framebuffer between renderer and screen driver;
//           banks swap on frame_sync when FB_DOUBLE_BUFFER_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module framebuffer_ctrl #(
    parameter int H_RES   = fb_pkg::H_RES,
    parameter int V_RES   = fb_pkg::V_RES,
    parameter int COLOR_W = fb_pkg::COLOR_W
) (
    input  logic               pixel_clock,
    input  logic               pixel_reset,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [COLOR_W-1:0] pix_data,
    input  logic               pix_last,
    input  logic               frame_sync,
    input  fb_pkg::fb_addr_t   addr_vga,
    output logic [COLOR_W-1:0] data_vga,
    input  fb_pkg::fb_addr_t   addr_lcd,
    output logic [COLOR_W-1:0] data_lcd,
    output logic               front_bank,
    output logic               frame_err
);

    import fb_pkg::*;

    localparam int       PIXELS    = H_RES * V_RES;
    localparam int       IDX_W     = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam fb_addr_t LAST_ADDR = fb_addr_t'(PIXELS - 1);
    localparam fb_addr_t ADDR_LIM  = fb_addr_t'(PIXELS);

`ifdef FB_DOUBLE_BUFFER_EN
    localparam bit DOUBLE_BUF = 1'b1;
`else
    localparam bit DOUBLE_BUF = 1'b0;
`endif

    fb_state_t r_state;
    fb_state_t w_state_next;
    logic      r_run;
    fb_addr_t  r_wr_addr;
    logic      r_front;
    logic      r_err;
    logic      r_sync_d1;
    logic      r_sync_d2;
    logic      r_oob_vga;
    logic      r_oob_lcd;

    logic w_accept;
    logic w_at_last;
    logic w_frame_end;
    logic w_sync_rise;
    logic w_swap;

    logic [COLOR_W-1:0] w_b0_vga;
    logic [COLOR_W-1:0] w_b0_lcd;
    logic [COLOR_W-1:0] w_b1_vga;
    logic [COLOR_W-1:0] w_b1_lcd;

    // r_run holds ready low during reset and for no longer than that
    assign pix_ready   = r_run && (r_state == FILL);
    assign w_accept    = pix_valid && pix_ready;
    assign w_at_last   = (r_wr_addr == LAST_ADDR);
    assign w_frame_end = w_accept && (pix_last || w_at_last);
    assign w_sync_rise = DOUBLE_BUF && r_sync_d1 && !r_sync_d2;

    always_ff @(posedge pixel_clock or posedge pixel_reset) begin
        if (pixel_reset) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_swap       = 1'b0;
        case (r_state)
            FILL: begin
                if (w_frame_end && DOUBLE_BUF) begin
                    w_state_next = WAIT_SWAP;
                end
            end
            WAIT_SWAP: begin
                if (w_sync_rise) begin
                    w_swap       = 1'b1;
                    w_state_next = FILL;
                end
            end
            default: begin
                w_state_next = FILL;
            end
        endcase
    end

    // Sync history resets high so a level already high at release is no edge
    always_ff @(posedge pixel_clock or posedge pixel_reset) begin
        if (pixel_reset) begin
            r_run     <= 1'b0;
            r_wr_addr <= '0;
            r_front   <= 1'b0;
            r_err     <= 1'b0;
            r_sync_d1 <= 1'b1;
            r_sync_d2 <= 1'b1;
            r_oob_vga <= 1'b1;
            r_oob_lcd <= 1'b1;
        end else begin
            r_run     <= 1'b1;
            r_sync_d1 <= frame_sync;
            r_sync_d2 <= r_sync_d1;
            r_oob_vga <= (addr_vga >= ADDR_LIM);
            r_oob_lcd <= (addr_lcd >= ADDR_LIM);
            if (w_accept) begin
                r_wr_addr <= w_frame_end ? '0 : r_wr_addr + 1'b1;
            end
            if (w_frame_end && (pix_last != w_at_last)) begin
                r_err <= 1'b1;
            end
            if (w_swap) begin
                r_front <= ~r_front;
            end
        end
    end

    generate
        if (DOUBLE_BUF) begin : g_double
            fb_bank #(
                .DEPTH (PIXELS),
                .WIDTH (COLOR_W),
                .IDX_W (IDX_W)
            ) u_bank0 (
                .clk       (pixel_clock),
                .we        (w_accept && r_front),
                .wr_idx    (r_wr_addr[IDX_W-1:0]),
                .wr_data   (pix_data),
                .rd_idx_a  (addr_vga[IDX_W-1:0]),
                .rd_idx_b  (addr_lcd[IDX_W-1:0]),
                .rd_data_a (w_b0_vga),
                .rd_data_b (w_b0_lcd)
            );

            fb_bank #(
                .DEPTH (PIXELS),
                .WIDTH (COLOR_W),
                .IDX_W (IDX_W)
            ) u_bank1 (
                .clk       (pixel_clock),
                .we        (w_accept && !r_front),
                .wr_idx    (r_wr_addr[IDX_W-1:0]),
                .wr_data   (pix_data),
                .rd_idx_a  (addr_vga[IDX_W-1:0]),
                .rd_idx_b  (addr_lcd[IDX_W-1:0]),
                .rd_data_a (w_b1_vga),
                .rd_data_b (w_b1_lcd)
            );
        end else begin : g_single
            fb_bank #(
                .DEPTH (PIXELS),
                .WIDTH (COLOR_W),
                .IDX_W (IDX_W)
            ) u_bank0 (
                .clk       (pixel_clock),
                .we        (w_accept),
                .wr_idx    (r_wr_addr[IDX_W-1:0]),
                .wr_data   (pix_data),
                .rd_idx_a  (addr_vga[IDX_W-1:0]),
                .rd_idx_b  (addr_lcd[IDX_W-1:0]),
                .rd_data_a (w_b0_vga),
                .rd_data_b (w_b0_lcd)
            );

            assign w_b1_vga = '0;
            assign w_b1_lcd = '0;
        end
    endgenerate

    // r_front already holds the post-edge bank, matching the registered read data
    assign data_vga   = r_oob_vga ? '0 : (r_front ? w_b1_vga : w_b0_vga);
    assign data_lcd   = r_oob_lcd ? '0 : (r_front ? w_b1_lcd : w_b0_lcd);
    assign front_bank = r_front;
    assign frame_err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_framebuffer_ctrl.sv
// ============================================================================
// Module  : tb_framebuffer_ctrl
// Brief   : Randomized self-checking bench for framebuffer_ctrl with a
//           frame-level reference model (reduced 32x8 geometry).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_framebuffer_ctrl;

    localparam int HR = 32;
    localparam int VR = 8;
    localparam int P  = HR * VR;

`ifdef FB_DOUBLE_BUFFER_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic        pixel_clock = 1'b0;
    logic        pixel_reset = 1'b0;
    logic        pix_valid   = 1'b0;
    logic        pix_ready;
    logic [3:0]  pix_data    = '0;
    logic        pix_last    = 1'b0;
    logic        frame_sync  = 1'b1;
    logic [18:0] addr_vga    = '0;
    logic [3:0]  data_vga;
    logic [18:0] addr_lcd    = '0;
    logic [3:0]  data_lcd;
    logic        front_bank;
    logic        frame_err;

    framebuffer_ctrl #(
        .H_RES   (HR),
        .V_RES   (VR),
        .COLOR_W (4)
    ) dut (
        .pixel_clock (pixel_clock),
        .pixel_reset (pixel_reset),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_last    (pix_last),
        .frame_sync  (frame_sync),
        .addr_vga    (addr_vga),
        .data_vga    (data_vga),
        .addr_lcd    (addr_lcd),
        .data_lcd    (data_lcd),
        .front_bank  (front_bank),
        .frame_err   (frame_err)
    );

    always #5 pixel_clock = ~pixel_clock;

    int total = 0;
    int bad   = 0;

    // Reference model: bank contents plus frame-level status
    int m_mem   [2][P];
    bit m_known [2][P];
    bit m_wait, m_run, m_front, m_err, m_s1, m_s2;
    int m_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_wait  = 1'b0;
        m_run   = 1'b0;
        m_front = 1'b0;
        m_err   = 1'b0;
        m_s1    = 1'b1;
        m_s2    = 1'b1;
        m_addr  = 0;
    endtask

    // One clock: predict this edge from the current inputs, then compare.
    task automatic step();
        bit ready, acc, swap, nf, at_last, kv, kl;
        int back, ev, el;
        ready = m_run && !m_wait;
        acc   = pix_valid && ready;
        swap  = DBL && m_wait && m_s1 && !m_s2;
        nf    = m_front ^ swap;
        if (int'(addr_vga) >= P) begin ev = 0; kv = 1'b1; end
        else begin ev = m_mem[nf][int'(addr_vga)]; kv = m_known[nf][int'(addr_vga)]; end
        if (int'(addr_lcd) >= P) begin el = 0; kl = 1'b1; end
        else begin el = m_mem[nf][int'(addr_lcd)]; kl = m_known[nf][int'(addr_lcd)]; end
        if (acc) begin
            back = DBL ? int'(!m_front) : 0;
            m_mem[back][m_addr]   = int'(pix_data);
            m_known[back][m_addr] = 1'b1;
            at_last = (m_addr == P - 1);
            if (pix_last || at_last) begin
                if (pix_last != at_last) m_err = 1'b1;
                m_addr = 0;
                m_wait = DBL;
            end else begin
                m_addr++;
            end
        end
        if (swap) begin
            m_front = nf;
            m_wait  = 1'b0;
        end
        m_s2  = m_s1;
        m_s1  = frame_sync;
        m_run = 1'b1;
        @(posedge pixel_clock);
        #1;
        chk("pix_ready", pix_ready, m_run && !m_wait);
        chk("front_bank", front_bank, m_front);
        chk("frame_err", frame_err, m_err);
        if (kv) chk("data_vga", data_vga, ev);
        if (kl) chk("data_lcd", data_lcd, el);
    endtask

    task automatic do_reset();
        pixel_reset = 1'b1;
        #1;
        chk("rst_ready", pix_ready, 0);
        chk("rst_front", front_bank, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_vga", data_vga, 0);
        chk("rst_lcd", data_lcd, 0);
        repeat (2) @(posedge pixel_clock);
        #1;
        pixel_reset = 1'b0;
        model_reset();
    endtask

    // Offer n beats with data (i*mul+add) mod 16; pix_last on beat last_idx.
    task automatic stream(input int n, input int last_idx, input int mul, input int add);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 4 * P + 64) begin
            pix_valid = 1'b1;
            pix_data  = 4'((i * mul + add) % 16);
            pix_last  = (i == last_idx);
            if (m_run && !m_wait) i++;
            step();
            guard++;
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        if (i < n) chk("stream_timeout", i, n);
    endtask

    task automatic sync_pulse();
        frame_sync = 1'b0;
        repeat (3) step();
        frame_sync = 1'b1;
        repeat (3) step();
    endtask

    initial begin
        bit saved;
        int fs_cnt;
        model_reset();
        @(posedge pixel_clock);
        #1;

        // reset released while frame_sync is already high
        frame_sync = 1'b1;
        do_reset();
        step();
        chk("ready_after_rst", pix_ready, 1);
        repeat (5) step();
        chk("no_swap_level", front_bank, 0);

        // full frame of index mod 16, then swap
        stream(P, P - 1, 1, 0);
        sync_pulse();
        chk("swap_full", front_bank, DBL ? 1 : 0);
        addr_vga = 19'd100;
        addr_lcd = 19'd100;
        step();
        chk("rd100_vga", data_vga, 4);
        chk("rd100_lcd", data_lcd, 4);
        chk("err_clean", frame_err, 0);

        // early pix_last on beat 99
        stream(100, 99, 5, 3);
        chk("err_early", frame_err, 1);
        repeat (3) step();
        chk("ready_hold", pix_ready, DBL ? 0 : 1);
        sync_pulse();

        // frame end lands on the same cycle as the swap point
        frame_sync = 1'b0;
        stream(48, -1, 7, 0);
        saved = front_bank;
        frame_sync = 1'b1;
        stream(1, -1, 7, 0);
        stream(1, 0, 7, 0);
        repeat (4) step();
        chk("coinc_noswap", front_bank, saved);
        sync_pulse();
        chk("coinc_swap", front_bank, DBL ? !saved : 1'b0);

        // out-of-range reads
        addr_vga = 19'(P);      addr_lcd = 19'(P);      step();
        chk("oob_p_vga", data_vga, 0);   chk("oob_p_lcd", data_lcd, 0);
        addr_vga = 19'd307200;  addr_lcd = 19'd307200;  step();
        chk("oob_big_vga", data_vga, 0); chk("oob_big_lcd", data_lcd, 0);
        addr_vga = 19'h7FFFF;   addr_lcd = 19'h7FFFF;   step();
        chk("oob_max_vga", data_vga, 0); chk("oob_max_lcd", data_lcd, 0);

        // randomized traffic
        fs_cnt = 10;
        for (int c = 0; c < 4000; c++) begin
            pix_valid = ($urandom % 4) != 0;
            pix_data  = 4'($urandom);
            pix_last  = ($urandom % 300) == 0;
            if (fs_cnt == 0) begin
                frame_sync = ~frame_sync;
                fs_cnt = int'($urandom_range(200, 5));
            end else begin
                fs_cnt--;
            end
            addr_vga = (($urandom % 16) == 0) ? 19'h7FFFF : 19'($urandom_range(P + 8, 0));
            addr_lcd = 19'($urandom_range(P + 8, 0));
            step();
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;

        // reset in the middle of a frame, then a fresh frame from address 0
        sync_pulse();
        stream(100, -1, 1, 0);
        frame_sync = 1'b1;
        do_reset();
        step();
        stream(P, P - 1, 3, 1);
        sync_pulse();
        addr_vga = 19'd0;
        addr_lcd = 19'd1;
        step();
        chk("restart_addr0", data_vga, 1);
        chk("restart_addr1", data_lcd, 4);
        for (int a = 0; a < P; a++) begin
            addr_vga = 19'(a);
            addr_lcd = 19'(P - 1 - a);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
